// File: rtl/game_pkg.sv
// Shared encodings for the reaction-time game FSM and its round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    GS_INIT    = 3'd0,
    GS_WAIT    = 3'd1,
    GS_GAME    = 3'd2,
    GS_ON_TIME = 3'd3,
    GS_LATE    = 3'd4,
    GS_EARLY   = 3'd5
  } game_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_SCORE,
    S_GAP,
    S_CLRWAIT,
    S_DIV,
    S_FIN
  } seq_state_e;

  localparam int LATE_PENALTY_DEF = 1000;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, W cycles per divide.
module seq_divider #(
  parameter int W     = 13,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [W-1:0]     dividend_i,
  input  logic [W-1:0]     divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;

  // The dividend shifts out of quo_q's MSB as quotient bits shift in at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, divisor_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      cnt_q <= CNT_W'(W);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (!diff[W]) begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
    end
  end

  assign busy_o     = (cnt_q != '0);
  assign done_o     = (cnt_q == CNT_W'(1));
  assign quotient_o = quo_q[OUT_W-1:0];

endmodule

// File: rtl/reaction_round_seq.sv
// Multi-round session sequencer for the reaction-time game: pulses the game FSM,
// scores each round and reports last/best/average time and early-press count.
module reaction_round_seq
  import game_pkg::*;
#(
  parameter int NUM_ROUNDS   = 5,
  parameter int TIME_W       = 10,
  parameter int LATE_PENALTY = LATE_PENALTY_DEF,
  parameter int GAP_MS       = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              user_start,
  input  logic              user_abort,
  input  logic [2:0]        game_state,
  input  logic [31:0]       ms_passed,
  input  logic              ms_tick,
  output logic              game_start,
  output logic              game_clear,
  output logic              busy,
  output logic              done,
  output logic [3:0]        round_idx,
  output logic [TIME_W-1:0] last_time,
  output logic [TIME_W-1:0] best_time,
  output logic [TIME_W-1:0] avg_time,
  output logic [3:0]        early_count
);

  localparam int                SUM_W    = TIME_W + $clog2(NUM_ROUNDS + 1);
  localparam int                GAP_W    = $clog2(GAP_MS + 1);
  localparam logic [TIME_W-1:0] PENALTY  = TIME_W'(LATE_PENALTY);
  localparam logic [3:0]        LAST_IDX = 4'(NUM_ROUNDS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_MS - 1);

  seq_state_e        state_q;
  logic [2:0]        res_q;
  logic [SUM_W-1:0]  sum_q;
  logic [GAP_W-1:0]  gap_q;
  logic [TIME_W-1:0] last_q, best_q, avg_q;
  logic [3:0]        round_q, early_q;
  logic              start_q, clear_q, busy_q, done_q;

  logic [TIME_W-1:0] score_d;
  logic              div_start_d, div_busy, div_done;
  logic [TIME_W-1:0] div_quo;
  logic              unused_ms_hi;

  assign unused_ms_hi = ^ms_passed[31:TIME_W];

  // The game counter is frozen while in SCORE, so the low bits are the reaction time.
  always_comb begin
    score_d = PENALTY;
    if (res_q == GS_ON_TIME) score_d = ms_passed[TIME_W-1:0];
  end

  assign div_start_d = (state_q == S_CLRWAIT) && (game_state == GS_INIT) &&
                       (round_q == LAST_IDX) && !user_abort && !div_busy;

  seq_divider #(.W(SUM_W), .OUT_W(TIME_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start_d),
    .dividend_i(sum_q),
    .divisor_i (SUM_W'(NUM_ROUNDS)),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      sum_q   <= '0;
      gap_q   <= '0;
      last_q  <= '0;
      best_q  <= '0;
      avg_q   <= '0;
      round_q <= '0;
      early_q <= '0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      // Abort outranks every other event in the same cycle.
      if (user_abort && state_q != S_IDLE) begin
        clear_q <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (user_start) begin
            sum_q   <= '0;
            round_q <= '0;
            early_q <= '0;
            best_q  <= '1;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state_q <= S_ARM;
          end
          S_ARM: state_q <= S_PLAY;
          S_PLAY: begin
            case (game_state)
              GS_ON_TIME, GS_LATE, GS_EARLY: begin
                res_q   <= game_state;
                state_q <= S_SCORE;
              end
              GS_INIT: begin
                start_q <= 1'b1;
                state_q <= S_ARM;
              end
              default: ;
            endcase
          end
          S_SCORE: begin
            last_q <= score_d;
            sum_q  <= sum_q + SUM_W'(score_d);
            if (score_d < best_q) best_q <= score_d;
            if (res_q == GS_EARLY) early_q <= early_q + 4'd1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end
          S_GAP: if (ms_tick) begin
            if (gap_q == GAP_LAST) begin
              clear_q <= 1'b1;
              state_q <= S_CLRWAIT;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          S_CLRWAIT: if (game_state == GS_INIT) begin
            if (round_q == LAST_IDX) begin
              if (!div_busy) state_q <= S_DIV;
            end else begin
              round_q <= round_q + 4'd1;
              start_q <= 1'b1;
              state_q <= S_ARM;
            end
          end
          S_DIV: if (div_done) state_q <= S_FIN;
          S_FIN: begin
            avg_q   <= div_quo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign game_start  = start_q;
  assign game_clear  = clear_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign round_idx   = round_q;
  assign last_time   = last_q;
  assign best_time   = best_q;
  assign avg_time    = avg_q;
  assign early_count = early_q;

endmodule

// File: tb/tb_reaction_round_seq.sv
// Directed bench for reaction_round_seq with a small behavioural game FSM stand-in.
module tb_reaction_round_seq;
  import game_pkg::*;

  logic        clk, rst, user_start, user_abort, ms_tick;
  logic [2:0]  game_state;
  logic [31:0] ms_passed;
  logic        game_start, game_clear, busy, done;
  logic [3:0]  round_idx, early_count;
  logic [9:0]  last_time, best_time, avg_time;

  int ncomp = 0;
  int nfail = 0;

  reaction_round_seq #(
    .NUM_ROUNDS(3), .TIME_W(10), .LATE_PENALTY(1000), .GAP_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .user_start(user_start), .user_abort(user_abort),
    .game_state(game_state), .ms_passed(ms_passed), .ms_tick(ms_tick),
    .game_start(game_start), .game_clear(game_clear), .busy(busy), .done(done),
    .round_idx(round_idx), .last_time(last_time), .best_time(best_time),
    .avg_time(avg_time), .early_count(early_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); user_start = 1'b1;
    @(negedge clk); user_start = 1'b0;
  endtask

  task automatic wait_start();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (game_start === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("start_pulse_seen", 32'(ok), 1);
    game_state = GS_WAIT;
  endtask

  task automatic give_result(input logic [2:0] outcome, input int t);
    @(negedge clk);
    check("start_one_cycle", 32'(game_start), 0);
    game_state = GS_GAME;
    @(negedge clk);
    ms_passed  = 32'(t);
    game_state = outcome;
  endtask

  task automatic finish_gap();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (game_clear === 1'b1) begin
        ok = 1'b1;
        game_state = GS_INIT;
        ms_passed  = 0;
        ms_tick    = 1'b0;
        break;
      end
      ms_tick = ~ms_tick;
    end
    check("clear_after_gap", 32'(ok), 1);
  endtask

  task automatic play_round(input logic [2:0] outcome, input int t);
    wait_start();
    give_result(outcome, t);
    finish_gap();
  endtask

  // From the clear of the last round: 1 CLRWAIT + 12 DIV + 1 FIN cycles.
  task automatic wait_done(input int exp_avg, input int exp_best, input int exp_early);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = i; break; end
    end
    check("done_latency", 32'(lat), 14);
    check("busy_falls_with_done", 32'(busy), 0);
    check("avg_time", 32'(avg_time), 32'(exp_avg));
    check("best_time", 32'(best_time), 32'(exp_best));
    check("early_count", 32'(early_count), 32'(exp_early));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; user_start = 1'b0; user_abort = 1'b0; ms_tick = 1'b0;
    game_state = GS_INIT; ms_passed = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_game_start", 32'(game_start), 0);
    check("rst_game_clear", 32'(game_clear), 0);
    check("rst_best", 32'(best_time), 0);
    check("rst_round_idx", 32'(round_idx), 0);
    rst = 1'b0;

    // Three on-time rounds.
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    play_round(GS_ON_TIME, 250);
    check("last_r0", 32'(last_time), 250);
    play_round(GS_ON_TIME, 180);
    play_round(GS_ON_TIME, 400);
    check("last_r2", 32'(last_time), 400);
    check("round_idx_last", 32'(round_idx), 2);
    wait_done(276, 180, 0);

    // Middle round pressed early.
    pulse_start();
    play_round(GS_ON_TIME, 250);
    play_round(GS_EARLY, 77);
    check("last_early", 32'(last_time), 1000);
    check("early_after_r1", 32'(early_count), 1);
    play_round(GS_ON_TIME, 400);
    wait_done(550, 250, 1);

    // All rounds late.
    pulse_start();
    play_round(GS_LATE, 0);
    play_round(GS_LATE, 0);
    play_round(GS_LATE, 0);
    wait_done(1000, 1000, 0);

    // Abort while round 1 sits in GAP.
    pulse_start();
    play_round(GS_ON_TIME, 250);
    wait_start();
    give_result(GS_ON_TIME, 300);
    @(negedge clk);
    @(negedge clk);
    user_abort = 1'b1;
    @(negedge clk);
    user_abort = 1'b0;
    check("abort_clear", 32'(game_clear), 1);
    check("abort_busy", 32'(busy), 0);
    game_state = GS_INIT;
    @(negedge clk);
    check("abort_clear_one_cycle", 32'(game_clear), 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 0);

    // Reset during DIV clears everything immediately.
    pulse_start();
    play_round(GS_ON_TIME, 250);
    play_round(GS_ON_TIME, 180);
    play_round(GS_ON_TIME, 400);
    repeat (4) @(negedge clk);
    check("busy_in_div", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_last", 32'(last_time), 0);
    check("async_rst_best", 32'(best_time), 0);
    check("async_rst_avg", 32'(avg_time), 0);
    check("async_rst_round", 32'(round_idx), 0);
    check("async_rst_clear", 32'(game_clear), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    play_round(GS_ON_TIME, 250);
    play_round(GS_ON_TIME, 180);
    play_round(GS_ON_TIME, 400);
    wait_done(276, 180, 0);

    // Game cleared from outside during PLAY restarts the same round.
    pulse_start();
    wait_start();
    @(negedge clk);
    game_state = GS_GAME;
    @(negedge clk);
    game_state = GS_INIT;
    wait_start();
    check("restart_round_idx", 32'(round_idx), 0);
    give_result(GS_ON_TIME, 250);
    finish_gap();
    play_round(GS_ON_TIME, 180);
    play_round(GS_ON_TIME, 400);
    check("restart_final_idx", 32'(round_idx), 2);
    wait_done(276, 180, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
